// File: rtl/mem_line_ctrl_if.sv
// mem_line_ctrl_if: cache-side request/response bus of the line controller
interface mem_line_ctrl_if #(
  parameter int ADDR_SIZE  = 16,
  parameter int LINE_WORDS = 8
);
  logic                         mem_w_line;
  logic                         mem_r_line;
  logic                         mem_w_one;
  logic                         mem_r_one;
  logic [ADDR_SIZE-1:0]         mem_addr;
  logic [LINE_WORDS-1:0][31:0]  line_store;
  logic [LINE_WORDS-1:0][31:0]  line_read;
  logic                         mem_ready;
  logic                         mem_done;
  modport master (
    output mem_w_line, mem_r_line, mem_w_one, mem_r_one, mem_addr, line_store,
    input  line_read, mem_ready, mem_done
  );
  modport slave (
    input  mem_w_line, mem_r_line, mem_w_one, mem_r_one, mem_addr, line_store,
    output line_read, mem_ready, mem_done
  );
endinterface

// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: moves cache lines or single words to/from a word-wide SRAM
module mem_line_ctrl #(
  parameter int ADDR_SIZE  = 16,
  parameter int LINE_WORDS = 8
) (
  input  logic                 clk,
  input  logic                 rst_l,
  mem_line_ctrl_if.slave       bus,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic [31:0]          sram_wdata,
  output logic                 sram_we,
  output logic                 sram_re,
  input  logic [31:0]          sram_rdata
);
  localparam int LW = $clog2(LINE_WORDS);
  localparam int CW = LW + 1;
  typedef enum logic [2:0] {IDLE, WR_LINE, RD_LINE, WR_ONE, RD_ONE, DONE} state_t;
  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [CW-1:0]               lim;
  logic [ADDR_SIZE-1:0]        base;
  logic [ADDR_SIZE-1:0]        nxt;
  logic [ADDR_SIZE-1:0]        line_base;
  logic [LINE_WORDS-1:0][31:0] data;
  logic                        pend;
  logic [LW-1:0]               pidx;
  logic                        any;
  assign any       = bus.mem_w_line | bus.mem_r_line | bus.mem_w_one | bus.mem_r_one;
  assign line_base = bus.mem_addr & ~ADDR_SIZE'(LINE_WORDS - 1);
  assign lim       = (state == WR_LINE || state == RD_LINE) ? CW'(LINE_WORDS) : CW'(1);
  assign nxt       = base + ADDR_SIZE'(cnt);
  // cnt counts accesses already issued; read data lands one cycle after its strobe
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= IDLE;
      cnt           <= '0;
      base          <= '0;
      data          <= '0;
      pend          <= 1'b0;
      pidx          <= '0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      sram_we       <= 1'b0;
      sram_re       <= 1'b0;
      bus.line_read <= '0;
      bus.mem_ready <= 1'b1;
      bus.mem_done  <= 1'b0;
    end else begin
      pend <= sram_re;
      pidx <= LW'(cnt - CW'(1));
      if (pend) bus.line_read[pidx] <= sram_rdata;
      case (state)
        IDLE: if (any) begin
          bus.mem_ready <= 1'b0;
          cnt           <= CW'(1);
          base          <= line_base;
          data          <= bus.line_store;
          sram_wdata    <= bus.line_store[0];
          if (bus.mem_w_line) begin
            state     <= WR_LINE;
            sram_we   <= 1'b1;
            sram_addr <= line_base;
          end else if (bus.mem_r_line) begin
            state     <= RD_LINE;
            sram_re   <= 1'b1;
            sram_addr <= line_base;
          end else if (bus.mem_w_one) begin
            state     <= WR_ONE;
            sram_we   <= 1'b1;
            sram_addr <= bus.mem_addr;
          end else begin
            state     <= RD_ONE;
            sram_re   <= 1'b1;
            sram_addr <= bus.mem_addr;
          end
        end
        WR_LINE, WR_ONE: if (cnt == lim) begin
          sram_we      <= 1'b0;
          bus.mem_done <= 1'b1;
          state        <= DONE;
        end else begin
          sram_addr  <= nxt;
          sram_wdata <= data[cnt[LW-1:0]];
          cnt        <= cnt + CW'(1);
        end
        RD_LINE, RD_ONE: if (!sram_re) begin
          bus.mem_done <= 1'b1;
          state        <= DONE;
        end else if (cnt == lim) begin
          sram_re <= 1'b0;
        end else begin
          sram_addr <= nxt;
          cnt       <= cnt + CW'(1);
        end
        DONE: if (!any) begin
          bus.mem_done  <= 1'b0;
          bus.mem_ready <= 1'b1;
          cnt           <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb_mem_line_ctrl: scoreboard bench with an SRAM model and a shadow memory
module tb_mem_line_ctrl;
  localparam int AS = 16;
  localparam int LW = 8;
  typedef logic [LW-1:0][31:0] line_t;
  typedef struct {bit we; logic [AS-1:0] addr; logic [31:0] data; int k;} acc_t;
  typedef struct {line_t line; int k;} res_t;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic [AS-1:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic sram_we, sram_re;
  bit [31:0] sram [65536];
  bit [31:0] ref_mem [65536];
  acc_t acc_q[$];
  res_t res_q[$];
  line_t exp_line = '0;
  int cyc = 0, c0 = 0, n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  mem_line_ctrl_if #(.ADDR_SIZE(AS), .LINE_WORDS(LW)) bus ();
  mem_line_ctrl #(.ADDR_SIZE(AS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_l(rst_l), .bus(bus.slave), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we(sram_we), .sram_re(sram_re), .sram_rdata(sram_rdata)
  );
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_we) sram[sram_addr] <= sram_wdata;
    sram_rdata <= sram_re ? sram[sram_addr] : 32'h0BAD_0BAD;
  end
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // every SRAM access must match the head of the expected-access queue
  always @(negedge clk) if (sram_we || sram_re) begin
    acc_t a;
    check("we_re_excl", 64'(sram_we & sram_re), 0);
    if (acc_q.size() == 0) check("unexp_acc", {sram_we, sram_re, sram_addr}, 0);
    else begin
      a = acc_q.pop_front();
      check("acc_kind", 64'(sram_we), 64'(a.we));
      check("acc_addr", 64'(sram_addr), 64'(a.addr));
      if (a.we) check("acc_data", 64'(sram_wdata), 64'(a.data));
      check("acc_cyc", 64'(cyc - c0 + 1), 64'(a.k));
    end
  end
  function automatic line_t mk(logic [31:0] b);
    for (int i = 0; i < LW; i++) mk[i] = b + 32'(i);
  endfunction
  task automatic exp_wline(logic [AS-1:0] addr, line_t d, int n);
    logic [AS-1:0] base = addr & ~AS'(LW - 1);
    for (int i = 0; i < n; i++) begin
      acc_q.push_back('{1'b1, AS'(base + AS'(i)), d[i], i + 1});
      ref_mem[AS'(base + AS'(i))] = d[i];
    end
    if (n == LW) res_q.push_back('{exp_line, LW + 1});
  endtask
  task automatic exp_rline(logic [AS-1:0] addr);
    logic [AS-1:0] base = addr & ~AS'(LW - 1);
    for (int i = 0; i < LW; i++) begin
      acc_q.push_back('{1'b0, AS'(base + AS'(i)), 32'h0, i + 1});
      exp_line[i] = ref_mem[AS'(base + AS'(i))];
    end
    res_q.push_back('{exp_line, LW + 2});
  endtask
  task automatic exp_one(bit we, logic [AS-1:0] addr, logic [31:0] d);
    acc_q.push_back('{we, addr, d, 1});
    if (we) ref_mem[addr] = d;
    else exp_line[0] = ref_mem[addr];
    res_q.push_back('{exp_line, we ? 2 : 3});
  endtask
  task automatic start(logic [3:0] stb, logic [AS-1:0] addr, line_t d);
    @(negedge clk);
    {bus.mem_w_line, bus.mem_r_line, bus.mem_w_one, bus.mem_r_one} = stb;
    bus.mem_addr = addr;
    bus.line_store = d;
    @(posedge clk);
    #1 c0 = cyc;
    bus.mem_addr = ~addr;
    bus.line_store = {LW{32'($urandom)}};
  endtask
  task automatic finish_txn(int hold);
    res_t r;
    if (res_q.size() == 0) begin
      check("res_q_empty", 0, 1);
      return;
    end
    r = res_q.pop_front();
    for (int n = 0; n < 40 && !bus.mem_done; n++) @(negedge clk);
    check("done_seen", 64'(bus.mem_done), 1);
    check("done_cyc", 64'(cyc - c0 + 1), 64'(r.k));
    for (int i = 0; i < LW; i++) check($sformatf("line_read[%0d]", i), 64'(bus.line_read[i]), 64'(r.line[i]));
    check("acc_left", 64'(acc_q.size()), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("done_hold", 64'(bus.mem_done), 1);
      check("ready_low", 64'(bus.mem_ready), 0);
      check("hold_line", 64'(bus.line_read[LW-1]), 64'(r.line[LW-1]));
    end
    {bus.mem_w_line, bus.mem_r_line, bus.mem_w_one, bus.mem_r_one} = 4'b0;
    @(posedge clk);
    #1 check("ready_back", 64'(bus.mem_ready), 1);
    check("done_clr", 64'(bus.mem_done), 0);
  endtask
  task automatic check_reset(string tag);
    check({tag, "_ready"}, 64'(bus.mem_ready), 1);
    check({tag, "_done"}, 64'(bus.mem_done), 0);
    check({tag, "_we_re"}, {sram_we, sram_re}, 0);
    check({tag, "_addr"}, 64'(sram_addr), 0);
    check({tag, "_wdata"}, 64'(sram_wdata), 0);
    for (int i = 0; i < LW; i++) check({tag, "_line"}, 64'(bus.line_read[i]), 0);
  endtask
  initial begin
    logic [AS-1:0] a;
    logic [31:0] d;
    {bus.mem_w_line, bus.mem_r_line, bus.mem_w_one, bus.mem_r_one} = 4'b0;
    bus.mem_addr = '0;
    bus.line_store = '0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_l = 1'b1;
    exp_wline(16'h0013, mk(32'hA0), LW);
    start(4'b1000, 16'h0013, mk(32'hA0));
    finish_txn(0);
    exp_rline(16'h0015);
    start(4'b0100, 16'h0015, '0);
    finish_txn(3);
    exp_one(1'b1, 16'h0042, 32'hDEADBEEF);
    start(4'b0010, 16'h0042, {mk(32'h0)[LW-1:1], 32'hDEADBEEF});
    finish_txn(1);
    exp_one(1'b0, 16'h0042, 32'h0);
    start(4'b0001, 16'h0042, '0);
    finish_txn(0);
    exp_wline(16'h0030, mk(32'hC0), LW);
    start(4'b1001, 16'h0030, mk(32'hC0));
    finish_txn(1);
    exp_wline(16'hFFFC, mk(32'hF0), LW);
    start(4'b1000, 16'hFFFC, mk(32'hF0));
    finish_txn(0);
    check("no_wrap_0000", 64'(sram[0]), 0);
    exp_rline(16'hFFF9);
    start(4'b0100, 16'hFFF9, '0);
    finish_txn(0);
    for (int t = 0; t < 4; t++) begin
      a = AS'($urandom);
      d = $urandom;
      exp_one(1'b1, a, d);
      start(4'b0010, a, {LW{d}});
      finish_txn(0);
      exp_one(1'b0, a, 32'h0);
      start(4'b0001, a, '0);
      finish_txn(0);
    end
    exp_wline(16'h0100, mk(32'hB0), 3);
    start(4'b1000, 16'h0100, mk(32'hB0));
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b0;
    {bus.mem_w_line, bus.mem_r_line, bus.mem_w_one, bus.mem_r_one} = 4'b0001;
    bus.mem_addr = 16'h0102;
    #1 check_reset("midrst");
    @(negedge clk);
    check("midrst_acc_left", 64'(acc_q.size()), 0);
    exp_line = '0;
    exp_one(1'b0, 16'h0102, 32'h0);
    rst_l = 1'b1;
    @(posedge clk);
    #1 c0 = cyc;
    finish_txn(0);
    exp_one(1'b0, 16'h0103, 32'h0);
    start(4'b0001, 16'h0103, '0);
    finish_txn(0);
    check("sram_0103", 64'(sram[16'h0103]), 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
